// File: rtl/stopwatch_input_conditioner_if.sv
// Board-side signal bundle for stopwatch_input_conditioner.
// master: drives the raw buttons/switches and reads the conditioned controls.
// slave:  the conditioner itself.
// With STOPWATCH_LONGPRESS_EN defined, the bundle also carries o_long_rst.
interface stopwatch_input_conditioner_if;
  logic btn_rst;
  logic btn_pause;
  logic sw_adj;
  logic sw_sel;
  logic o_rst_pulse;
  logic o_pause;
  logic o_adj;
  logic o_sel;
`ifdef STOPWATCH_LONGPRESS_EN
  logic o_long_rst;

  modport master (
    output btn_rst, btn_pause, sw_adj, sw_sel,
    input  o_rst_pulse, o_pause, o_adj, o_sel, o_long_rst
  );

  modport slave (
    input  btn_rst, btn_pause, sw_adj, sw_sel,
    output o_rst_pulse, o_pause, o_adj, o_sel, o_long_rst
  );
`else
  modport master (
    output btn_rst, btn_pause, sw_adj, sw_sel,
    input  o_rst_pulse, o_pause, o_adj, o_sel
  );

  modport slave (
    input  btn_rst, btn_pause, sw_adj, sw_sel,
    output o_rst_pulse, o_pause, o_adj, o_sel
  );
`endif
endinterface

// File: rtl/stopwatch_input_conditioner.sv
// Front end for the stopwatch: synchronizes and debounces the raw board
// buttons/switches, then derives the control signals for minsec_counter.
//   o_adj / o_sel : debounced switch levels
//   o_rst_pulse   : one cycle after a debounced btn_rst press
//   o_pause       : toggled by each debounced btn_pause press, cleared by reset pulse
// Optional feature macro: STOPWATCH_LONGPRESS_EN adds o_long_rst, a single
// pulse once btn_rst has been stably held for LONG_CYCLES cycles.
module stopwatch_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter int LONG_CYCLES     = 200000000
) (
  input logic                          i_clk,
  input logic                          i_rst,
  stopwatch_input_conditioner_if.slave bus
);

  localparam int NUM_CH   = 4;
  localparam int CH_RST   = 0;
  localparam int CH_PAUSE = 1;
  localparam int CH_ADJ   = 2;
  localparam int CH_SEL   = 3;

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject illegal configurations at elaboration.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("LONG_CYCLES must be >= 1");
  end

  logic [NUM_CH-1:0]      raw;
  logic [SYNC_STAGES-1:0] sync_q   [NUM_CH];
  logic [CNT_W-1:0]       cnt_q    [NUM_CH];
  logic [NUM_CH-1:0]      stable_q;
  logic                   rst_d_q;
  logic                   pause_d_q;
  logic                   rst_pulse_q;
  logic                   pause_q;
  logic                   rst_rise;
  logic                   pause_rise;

  assign raw = {bus.sw_sel, bus.sw_adj, bus.btn_pause, bus.btn_rst};

  // Per-channel synchronizer chain; bit SYNC_STAGES-1 is the synced value.
  // NOTE: every register uses non-blocking assignment so all flops sample
  // pre-edge values; the synchronizer chain is reset like any other flop.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) sync_q[ch] <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++)
        sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
    end
  end

  // Debounce: stable follows synced only after DEBOUNCE_CYCLES consecutive
  // differing cycles; any agreement restarts the count, so it never wraps.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) cnt_q[ch] <= '0;
      stable_q <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (sync_q[ch][SYNC_STAGES-1] == stable_q[ch]) begin
          cnt_q[ch] <= '0;
        end else if (cnt_q[ch] == CNT_LAST) begin
          stable_q[ch] <= sync_q[ch][SYNC_STAGES-1];
          cnt_q[ch]    <= '0;
        end else begin
          cnt_q[ch] <= cnt_q[ch] + 1'b1;
        end
      end
    end
  end

  assign rst_rise   = stable_q[CH_RST]   & ~rst_d_q;
  assign pause_rise = stable_q[CH_PAUSE] & ~pause_d_q;

  // Edge history plus derived controls; the reset pulse wins over a pause toggle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rst_d_q     <= 1'b0;
      pause_d_q   <= 1'b0;
      rst_pulse_q <= 1'b0;
      pause_q     <= 1'b0;
    end else begin
      rst_d_q     <= stable_q[CH_RST];
      pause_d_q   <= stable_q[CH_PAUSE];
      rst_pulse_q <= rst_rise;
      if (rst_rise) begin
        pause_q <= 1'b0;
      end else if (pause_rise) begin
        pause_q <= ~pause_q;
      end
    end
  end

  assign bus.o_rst_pulse = rst_pulse_q;
  assign bus.o_pause     = pause_q;
  assign bus.o_adj       = stable_q[CH_ADJ];
  assign bus.o_sel       = stable_q[CH_SEL];

`ifdef STOPWATCH_LONGPRESS_EN
  localparam int               HOLD_W   = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_q;
  logic              long_q;

  // Hold timer: counts while stable_rst is high, saturates at LONG_CYCLES so
  // exactly one long-press pulse is produced per hold.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (!stable_q[CH_RST]) begin
        hold_q <= '0;
      end else if (hold_q != HOLD_MAX) begin
        hold_q <= hold_q + 1'b1;
        long_q <= (hold_q == HOLD_MAX - 1'b1);
      end
    end
  end

  assign bus.o_long_rst = long_q;
`endif

endmodule

// File: tb/tb_stopwatch_input_conditioner.sv
// Self-checking bench for stopwatch_input_conditioner with
// DEBOUNCE_CYCLES=4, SYNC_STAGES=2, LONG_CYCLES=20. The reference model keeps
// a window of raw samples and synced observations and applies the debounce
// rule directly ("the last DEBOUNCE_CYCLES observations all disagree").
module tb_stopwatch_input_conditioner;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int LONG = 20;
  localparam int CH_RST   = 0;
  localparam int CH_PAUSE = 1;
  localparam int CH_ADJ   = 2;
  localparam int CH_SEL   = 3;
`ifdef STOPWATCH_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  stopwatch_input_conditioner_if bus ();

  stopwatch_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC),
    .LONG_CYCLES    (LONG)
  ) u_dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  logic [3:0] raw_q[$];
  logic [3:0] obs_q[$];
  logic [3:0] m_stable;
  logic [3:0] m_stable_prev;
  logic       m_pulse;
  logic       m_pause;
  logic       m_long;
  int         m_hold;

  task automatic model_reset();
    raw_q.delete();
    obs_q.delete();
    m_stable      = '0;
    m_stable_prev = '0;
    m_pulse       = 1'b0;
    m_pause       = 1'b0;
    m_long        = 1'b0;
    m_hold        = 0;
  endtask

  task automatic model_step(input logic [3:0] raw);
    logic [3:0] obs;
    logic       rise_r;
    logic       rise_p;
    bit         all_diff;
    rise_r  = m_stable[CH_RST]   & ~m_stable_prev[CH_RST];
    rise_p  = m_stable[CH_PAUSE] & ~m_stable_prev[CH_PAUSE];
    m_pulse = rise_r;
    if (rise_r)      m_pause = 1'b0;
    else if (rise_p) m_pause = ~m_pause;
    m_hold = m_stable[CH_RST] ? m_hold + 1 : 0;
    m_long = (m_hold == LONG);
    raw_q.push_back(raw);
    obs = (raw_q.size() > SYNC) ? raw_q[raw_q.size() - 1 - SYNC] : 4'b0;
    if (raw_q.size() > SYNC + 1) void'(raw_q.pop_front());
    obs_q.push_back(obs);
    if (obs_q.size() > DEB) void'(obs_q.pop_front());
    m_stable_prev = m_stable;
    for (int ch = 0; ch < 4; ch++) begin
      all_diff = (obs_q.size() == DEB);
      foreach (obs_q[i]) if (obs_q[i][ch] == m_stable[ch]) all_diff = 1'b0;
      if (all_diff) m_stable[ch] = ~m_stable[ch];
    end
  endtask

  function automatic logic [4:0] exp_outs();
    return {LONG_EN & m_long, m_pulse, m_pause, m_stable[CH_ADJ], m_stable[CH_SEL]};
  endfunction

  function automatic logic [4:0] dut_outs();
`ifdef STOPWATCH_LONGPRESS_EN
    return {bus.o_long_rst, bus.o_rst_pulse, bus.o_pause, bus.o_adj, bus.o_sel};
`else
    return {1'b0, bus.o_rst_pulse, bus.o_pause, bus.o_adj, bus.o_sel};
`endif
  endfunction

  // Raw input vector order: {sw_sel, sw_adj, btn_pause, btn_rst}
  task automatic drive(input logic [3:0] v);
    {bus.sw_sel, bus.sw_adj, bus.btn_pause, bus.btn_rst} = v;
  endtask

  // One clock: model steps on the edge, outputs are then read at the negedge.
  task automatic tick();
    @(posedge i_clk);
    if (i_rst) model_step({bus.sw_sel, bus.sw_adj, bus.btn_pause, bus.btn_rst});
    cyc++;
    @(negedge i_clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_reset();
    for (int i = 0; i < 12; i++) begin
      drive(4'($urandom));
      tick();
      n_checks++;
      if (dut_outs() !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: outputs %b, required 00000", cyc, dut_outs());
      end
    end
    drive(4'b0000);
    i_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (dut_outs() !== exp_outs()) begin
        n_fail++;
        $display("FAIL reset_release cycle %0d: outputs %b, required %b", cyc, dut_outs(), exp_outs());
      end
    end
  endtask

  task automatic test_adj_sel();
    int lat = -1;
    drive(4'b0100);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (lat < 0 && bus.o_adj === 1'b1) lat = i;
      n_checks++;
      if (dut_outs() !== exp_outs()) begin
        n_fail++;
        $display("FAIL adj_rise cycle %0d: outputs %b, required %b", cyc, dut_outs(), exp_outs());
      end
    end
    n_checks++;
    if (lat !== SYNC + DEB) begin
      n_fail++;
      $display("FAIL adj_latency: observed %0d cycles, required %0d", lat, SYNC + DEB);
    end
    for (int i = 0; i < 13; i++) begin
      drive((i < 3) ? 4'b1100 : 4'b0100);
      tick();
      n_checks++;
      if (bus.o_sel !== 1'b0 || dut_outs() !== exp_outs()) begin
        n_fail++;
        $display("FAIL sel_glitch cycle %0d: outputs %b, required %b", cyc, dut_outs(), exp_outs());
      end
    end
    drive(4'b0000);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (dut_outs() !== exp_outs()) begin
        n_fail++;
        $display("FAIL adj_fall cycle %0d: outputs %b, required %b", cyc, dut_outs(), exp_outs());
      end
    end
  endtask

  task automatic test_pause_bounce();
    logic seq[$];
    logic prev;
    int   toggles = 0;
    seq = '{1, 0, 1, 1, 0};
    for (int i = 0; i < 10; i++) seq.push_back(1'b1);
    for (int i = 0; i < 10; i++) seq.push_back(1'b0);
    for (int i = 0; i < 10; i++) seq.push_back(1'b1);
    for (int i = 0; i < 10; i++) seq.push_back(1'b0);
    prev = bus.o_pause;
    foreach (seq[k]) begin
      drive({2'b00, seq[k], 1'b0});
      tick();
      if (bus.o_pause !== prev) toggles++;
      prev = bus.o_pause;
      n_checks++;
      if (dut_outs() !== exp_outs()) begin
        n_fail++;
        $display("FAIL pause_bounce cycle %0d: outputs %b, required %b", cyc, dut_outs(), exp_outs());
      end
      if (k == 24) begin
        n_checks++;
        if (toggles != 1 || bus.o_pause !== 1'b1) begin
          n_fail++;
          $display("FAIL pause_first_press: toggles %0d level %b, required 1 toggle level 1", toggles, bus.o_pause);
        end
      end
    end
    n_checks++;
    if (toggles != 2 || bus.o_pause !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_second_press: toggles %0d level %b, required 2 toggles level 0", toggles, bus.o_pause);
    end
  endtask

  task automatic test_rst_pulse();
    int pulses = 0;
    logic pause_at_pulse = 1'bx;
    for (int i = 0; i < 20; i++) begin
      drive((i < 10) ? 4'b0010 : 4'b0000);
      tick();
      n_checks++;
      if (dut_outs() !== exp_outs()) begin
        n_fail++;
        $display("FAIL rst_setup cycle %0d: outputs %b, required %b", cyc, dut_outs(), exp_outs());
      end
    end
    n_checks++;
    if (bus.o_pause !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_setup_pause: o_pause %b, required 1", bus.o_pause);
    end
    for (int i = 0; i < 60; i++) begin
      drive((i < 50) ? 4'b0001 : 4'b0000);
      tick();
      if (bus.o_rst_pulse === 1'b1) begin
        pulses++;
        pause_at_pulse = bus.o_pause;
      end
      n_checks++;
      if (dut_outs() !== exp_outs()) begin
        n_fail++;
        $display("FAIL rst_hold cycle %0d: outputs %b, required %b", cyc, dut_outs(), exp_outs());
      end
    end
    n_checks++;
    if (pulses != 1 || pause_at_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_single_pulse: pulses %0d pause %b, required 1 pulse pause 0", pulses, pause_at_pulse);
    end
  endtask

  task automatic test_simultaneous();
    int pulses = 0;
    for (int i = 0; i < 20; i++) begin
      drive((i < 10) ? 4'b0010 : 4'b0000);
      tick();
    end
    for (int i = 0; i < 24; i++) begin
      drive((i < 12) ? 4'b0011 : 4'b0000);
      tick();
      if (bus.o_rst_pulse === 1'b1) begin
        pulses++;
        n_checks++;
        if (bus.o_pause !== 1'b0) begin
          n_fail++;
          $display("FAIL simul_pause: o_pause %b during reset pulse, required 0", bus.o_pause);
        end
      end
      n_checks++;
      if (dut_outs() !== exp_outs()) begin
        n_fail++;
        $display("FAIL simul cycle %0d: outputs %b, required %b", cyc, dut_outs(), exp_outs());
      end
    end
    n_checks++;
    if (pulses != 1 || bus.o_pause !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_summary: pulses %0d pause %b, required 1 pulse pause 0", pulses, bus.o_pause);
    end
  endtask

`ifdef STOPWATCH_LONGPRESS_EN
  task automatic test_long_press();
    int p_at = -1;
    int l_at = -1;
    int longs = 0;
    for (int i = 0; i < 50; i++) begin
      drive((i < 40) ? 4'b0001 : 4'b0000);
      tick();
      if (bus.o_rst_pulse === 1'b1 && p_at < 0) p_at = i;
      if (bus.o_long_rst === 1'b1) begin
        longs++;
        l_at = i;
      end
      n_checks++;
      if (dut_outs() !== exp_outs()) begin
        n_fail++;
        $display("FAIL long_hold cycle %0d: outputs %b, required %b", cyc, dut_outs(), exp_outs());
      end
    end
    n_checks++;
    if (longs != 1 || p_at < 0 || (l_at - p_at) != LONG - 1) begin
      n_fail++;
      $display("FAIL long_pulse: count %0d offset %0d, required 1 at offset %0d", longs, l_at - p_at, LONG - 1);
    end
    longs = 0;
    for (int i = 0; i < 20; i++) begin
      drive((i < 10) ? 4'b0001 : 4'b0000);
      tick();
      if (bus.o_long_rst === 1'b1) longs++;
    end
    n_checks++;
    if (longs != 0) begin
      n_fail++;
      $display("FAIL long_short_press: count %0d, required 0", longs);
    end
  endtask
`endif

  task automatic test_random();
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      len = $urandom_range(7, 1);
      drive(4'($urandom));
      for (int i = 0; i < len; i++) begin
        tick();
        n_checks++;
        if (dut_outs() !== exp_outs()) begin
          n_fail++;
          $display("FAIL random cycle %0d: outputs %b, required %b", cyc, dut_outs(), exp_outs());
        end
      end
    end
    drive(4'b0000);
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_async_reset();
    int lat = -1;
    int pulses = 0;
    drive(4'b1000);
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (bus.o_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL async_setup: o_sel %b, required 1", bus.o_sel);
    end
    drive(4'b1100);
    for (int i = 0; i < 4; i++) tick();
    #2;
    i_rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_outs() !== 5'b0) begin
      n_fail++;
      $display("FAIL async_clear: outputs %b before next edge, required 00000", dut_outs());
    end
    drive(4'b0101);
    @(negedge i_clk);
    i_rst = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (lat < 0 && bus.o_adj === 1'b1) lat = i;
      if (bus.o_rst_pulse === 1'b1) pulses++;
      n_checks++;
      if (dut_outs() !== exp_outs()) begin
        n_fail++;
        $display("FAIL async_release cycle %0d: outputs %b, required %b", cyc, dut_outs(), exp_outs());
      end
    end
    n_checks++;
    if (lat != SYNC + DEB || pulses != 1) begin
      n_fail++;
      $display("FAIL held_through_reset: adj latency %0d pulses %0d, required %0d and 1", lat, pulses, SYNC + DEB);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(4'b0000);
    @(negedge i_clk);
    test_reset();
    test_adj_sel();
    test_pause_bounce();
    test_rst_pulse();
    test_simultaneous();
`ifdef STOPWATCH_LONGPRESS_EN
    test_long_press();
`endif
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_input_conditioner.md
Name: stopwatch_input_conditioner

Overview:
- Front-end stage ahead of minsec_counter in the stopwatch top.
- Takes raw board buttons and switches, synchronizes them to i_clk and debounces them.
- Produces clean control signals: debounced ADJ/SEL levels, a one-cycle reset pulse, and a latched pause level for the counter.
- All channels share one clock domain; each channel has its own debounce counter.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive cycles a synchronized input must differ from its stable value before the stable value updates (5 ms at 100 MHz); legal range ≥1.
- SYNC_STAGES, 2: flip-flop stages in each input synchronizer; legal range ≥2.
- LONG_CYCLES, 200000000: hold time for the long-press output (optional feature only).

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  asynchronous, active-low reset
- btn_rst  input  1  raw stopwatch-reset button, active-high, asynchronous to i_clk
- btn_pause  input  1  raw pause button, active-high, asynchronous
- sw_adj  input  1  raw ADJ switch
- sw_sel  input  1  raw SEL switch
- o_rst_pulse  output  1  one-cycle pulse on debounced btn_rst press
- o_pause  output  1  pause level, toggled by each debounced btn_pause press
- o_adj  output  1  debounced ADJ level
- o_sel  output  1  debounced SEL level

Behaviour:
- Reset: i_rst low asynchronously clears all synchronizer flops, all debounce counters, all stable registers, all edge-history registers and all outputs to 0. Release is sampled on the i_clk rising edge.
- Synchronizer: each raw input passes through SYNC_STAGES flops; the last stage is "synced".
- Debounce, per channel:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - If synced == stable, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter would reach DEBOUNCE_CYCLES, stable takes synced and the counter clears in the same cycle.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable. A bounce resets accumulation.
- Latency: from a clean raw edge to the stable change is SYNC_STAGES + DEBOUNCE_CYCLES cycles. Derived outputs (pulse, toggle) appear one cycle after the stable change.
- o_adj and o_sel are the stable registers, registered outputs, with no further processing.
- o_rst_pulse: high for exactly one cycle on the cycle after stable_rst rises 0→1. No pulse on release. Holding the button produces a single pulse.
- o_pause: toggles on the cycle after a stable_pause 0→1 edge.
- o_rst_pulse also forces o_pause to 0, so a reset restarts the count running.
- Simultaneous rst and pause edges in the same cycle: o_rst_pulse=1 and o_pause=0; reset wins.
- Inputs held high through reset release: stable starts at 0, then rises after the full latency. Consequently a held btn_rst produces one o_rst_pulse after reset; this is the decided behaviour.
- Reset asserted mid-debounce: the counter is lost; accumulation restarts from 0 after release.
- Counters saturate by design: they can never exceed DEBOUNCE_CYCLES, so there is no wrap.

Optional Feature:
- Macro: STOPWATCH_LONGPRESS_EN.
- When defined:
  - Adds output o_long_rst (1 bit) and a hold counter of width $clog2(LONG_CYCLES+1).
  - The counter runs while stable_rst=1 and clears when stable_rst=0.
  - When it reaches LONG_CYCLES, o_long_rst pulses high for one cycle and the counter holds (saturates) until release, so only one pulse is produced per hold.
  - o_long_rst resets to 0.
- When undefined: the port, counter and logic are absent, and LONG_CYCLES is unused.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, LONG_CYCLES=20):
- i_rst low with random raw inputs toggling -> all outputs stay 0. Assert i_rst mid-cycle -> outputs clear immediately, without waiting for i_clk.
- sw_adj 0→1 held clean -> o_adj rises exactly 6 cycles after the first sampling edge. A 3-cycle-wide pulse on sw_sel -> o_sel stays 0.
- btn_pause bounces (1,0,1,1,0 per cycle) then held high for 10 cycles -> o_pause toggles 0→1 once, only after 4 consecutive synced highs. A second clean press -> o_pause back to 0.
- btn_rst pressed clean while o_pause=1 -> o_rst_pulse high for exactly 1 cycle, o_pause=0 in that same cycle. Holding btn_rst for 50 cycles -> no further pulses.
- btn_rst and btn_pause pressed on the same cycle -> o_rst_pulse=1 and o_pause=0.
- STOPWATCH_LONGPRESS_EN defined, btn_rst held for 40 cycles -> o_long_rst pulses once, 20 cycles after stable_rst rises. Release then re-press for 10 cycles -> no o_long_rst.
